// File: rtl/orpsoc_core_rst_seq_pkg.sv
// Shared types and constants for the ORPSoC multi-core reset sequencer.
package orpsoc_rst_pkg;

    typedef enum logic [1:0] {
        ST_POR = 2'd0,
        ST_REL = 2'd1,
        ST_RUN = 2'd2
    } rst_state_e;

    localparam int DEF_NUM_CORES      = 2;
    localparam int DEF_POR_CYCLES     = 50;
    localparam int DEF_STAGGER_CYCLES = 8;
    localparam int DEF_HOLD_CYCLES    = 16;
    localparam int DEF_WDT_CYCLES     = 4096;

    // Bits needed to hold 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        if (max_val < 1) begin
            return 1;
        end else begin
            return $clog2(max_val + 1);
        end
    endfunction

endpackage

// File: rtl/orpsoc_core_rst_seq_if.sv
// Control/status bundle between the reset sequencer and its environment.
interface orpsoc_core_rst_seq_if #(
    parameter int NUM_CORES = 2
);
    logic [NUM_CORES-1:0] core_en_i;
    logic [NUM_CORES-1:0] soft_rst_req_i;
    logic [NUM_CORES-1:0] core_alive_i;
    logic                 wdt_clr_i;
    logic                 sys_rst_o;
    logic [NUM_CORES-1:0] core_rst_o;
    logic [NUM_CORES-1:0] core_timeout_o;
    logic                 seq_done_o;

    modport master (
        output core_en_i, soft_rst_req_i, core_alive_i, wdt_clr_i,
        input  sys_rst_o, core_rst_o, core_timeout_o, seq_done_o
    );

    modport slave (
        input  core_en_i, soft_rst_req_i, core_alive_i, wdt_clr_i,
        output sys_rst_o, core_rst_o, core_timeout_o, seq_done_o
    );
endinterface

// File: rtl/orpsoc_core_rst_seq_wdt.sv
// Per-core reset hold counter plus optional inactivity watchdog.
// Watchdog logic is only built when ORPSOC_CORE_WDT_EN is defined.
module orpsoc_core_wdt
    import orpsoc_rst_pkg::*;
#(
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int WDT_CYCLES  = DEF_WDT_CYCLES
) (
    input  logic wb_clk_i,
    input  logic wb_rst_ni,
    input  logic i_run,
    input  logic i_go,
    input  logic i_en,
    input  logic i_soft_req,
    input  logic i_alive,
    input  logic i_wdt_clr,
    output logic o_core_rst,
    output logic o_timeout
);
    localparam int HOLD_W = cnt_width(HOLD_CYCLES);

    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic              r_en_q;
    logic              r_core_rst;
    logic              w_wdt_fire;

`ifdef ORPSOC_CORE_WDT_EN
    localparam int WDT_W = cnt_width(WDT_CYCLES);

    logic [WDT_W-1:0] r_wdt_cnt;
    logic             r_timeout;

    // Fire one cycle early so flag and reset rise on the terminal-count edge.
    assign w_wdt_fire = ~r_core_rst & ~i_alive &
                        (r_wdt_cnt == WDT_W'(WDT_CYCLES - 1));

    // Inactivity counter: cleared by reset or heartbeat, saturating otherwise.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_wdt_cnt <= '0;
        end else if (r_core_rst || i_alive) begin
            r_wdt_cnt <= '0;
        end else if (r_wdt_cnt != WDT_W'(WDT_CYCLES)) begin
            r_wdt_cnt <= r_wdt_cnt + WDT_W'(1);
        end else begin
            r_wdt_cnt <= r_wdt_cnt;
        end
    end

    // Sticky timeout flag; a new timeout beats a simultaneous clear.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_timeout <= 1'b0;
        end else if (w_wdt_fire) begin
            r_timeout <= 1'b1;
        end else if (i_wdt_clr) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= r_timeout;
        end
    end

    assign o_timeout = r_timeout;
`else
    logic w_unused_wdt;

    assign w_unused_wdt = i_alive ^ i_wdt_clr;
    assign w_wdt_fire   = 1'b0;
    assign o_timeout    = 1'b0;
`endif

    // Hold counter: (re)loaded by soft request, enable rise or watchdog.
    always_comb begin
        w_hold_nxt = r_hold;
        if (w_wdt_fire || (i_run && (i_soft_req || (i_en && !r_en_q)))) begin
            w_hold_nxt = HOLD_W'(HOLD_CYCLES);
        end else if (r_hold != '0) begin
            w_hold_nxt = r_hold - HOLD_W'(1);
        end else begin
            w_hold_nxt = r_hold;
        end
    end

    // Hold counter, enable history and the registered core reset.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_hold     <= '0;
            r_en_q     <= 1'b0;
            r_core_rst <= 1'b1;
        end else begin
            r_hold     <= w_hold_nxt;
            r_en_q     <= i_en;
            r_core_rst <= ~(i_go & i_en) | (w_hold_nxt != '0);
        end
    end

    assign o_core_rst = r_core_rst;

endmodule

// File: rtl/orpsoc_core_rst_seq.sv
// Multi-core reset sequencer: POR interval, staggered core release, soft
// reset and optional watchdog (ORPSOC_CORE_WDT_EN) per core.
module orpsoc_core_rst_seq
    import orpsoc_rst_pkg::*;
#(
    parameter int NUM_CORES      = DEF_NUM_CORES,
    parameter int POR_CYCLES     = DEF_POR_CYCLES,
    parameter int STAGGER_CYCLES = DEF_STAGGER_CYCLES,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int WDT_CYCLES     = DEF_WDT_CYCLES
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    orpsoc_core_rst_seq_if.slave  bus
);
    localparam int POR_W  = cnt_width(POR_CYCLES);
    localparam int STG_W  = cnt_width(STAGGER_CYCLES);
    localparam int SLOT_W = cnt_width(NUM_CORES - 1);

    logic [1:0]           r_sync;
    logic                 w_srst;
    rst_state_e           r_state;
    rst_state_e           w_state_nxt;
    logic [POR_W-1:0]     r_por_cnt;
    logic [STG_W-1:0]     r_stg_cnt;
    logic [SLOT_W-1:0]    r_slot;
    logic                 w_por_done;
    logic                 w_slot_end;
    logic                 w_last_slot;
    logic                 w_run;
    logic [NUM_CORES-1:0] w_go;
    logic                 w_sys_rst_nxt;
    logic                 w_done_nxt;
    logic                 r_sys_rst;
    logic                 r_seq_done;
    logic [NUM_CORES-1:0] w_core_rst;
    logic [NUM_CORES-1:0] w_timeout;

    // Reset-release synchroniser; assertion stays asynchronous.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], 1'b1};
        end
    end

    assign w_srst      = ~r_sync[1];
    assign w_por_done  = (r_state == ST_POR) && (r_por_cnt == POR_W'(POR_CYCLES));
    assign w_slot_end  = (r_state == ST_REL) && (r_stg_cnt == STG_W'(STAGGER_CYCLES - 1));
    assign w_last_slot = (r_slot == SLOT_W'(NUM_CORES - 1));
    assign w_run       = (r_state == ST_RUN);

    // FSM state register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= ST_POR;
        end else if (w_srst) begin
            r_state <= ST_POR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_POR: begin
                if (w_por_done) begin
                    w_state_nxt = ST_REL;
                end else begin
                    w_state_nxt = ST_POR;
                end
            end
            ST_REL: begin
                if (w_slot_end && w_last_slot) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_REL;
                end
            end
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_POR;
        endcase
    end

    // FSM output decode, taken from the next state so the registers line up.
    always_comb begin
        w_sys_rst_nxt = 1'b1;
        w_done_nxt    = 1'b0;
        case (w_state_nxt)
            ST_POR: begin
                w_sys_rst_nxt = 1'b1;
                w_done_nxt    = 1'b0;
            end
            ST_REL: begin
                w_sys_rst_nxt = 1'b0;
                w_done_nxt    = 1'b0;
            end
            ST_RUN: begin
                w_sys_rst_nxt = 1'b0;
                w_done_nxt    = 1'b1;
            end
            default: begin
                w_sys_rst_nxt = 1'b1;
                w_done_nxt    = 1'b0;
            end
        endcase
    end

    // Registered sequencer outputs.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_sys_rst  <= 1'b1;
            r_seq_done <= 1'b0;
        end else if (w_srst) begin
            r_sys_rst  <= 1'b1;
            r_seq_done <= 1'b0;
        end else begin
            r_sys_rst  <= w_sys_rst_nxt;
            r_seq_done <= w_done_nxt;
        end
    end

    // POR, stagger and slot counters.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_por_cnt <= '0;
            r_stg_cnt <= '0;
            r_slot    <= '0;
        end else if (w_srst) begin
            r_por_cnt <= '0;
            r_stg_cnt <= '0;
            r_slot    <= '0;
        end else begin
            case (r_state)
                ST_POR: begin
                    r_stg_cnt <= '0;
                    r_slot    <= '0;
                    if (w_por_done) begin
                        r_por_cnt <= '0;
                    end else begin
                        r_por_cnt <= r_por_cnt + POR_W'(1);
                    end
                end
                ST_REL: begin
                    r_por_cnt <= '0;
                    if (w_slot_end) begin
                        r_stg_cnt <= '0;
                        if (w_last_slot) begin
                            r_slot <= r_slot;
                        end else begin
                            r_slot <= r_slot + SLOT_W'(1);
                        end
                    end else begin
                        r_stg_cnt <= r_stg_cnt + STG_W'(1);
                        r_slot    <= r_slot;
                    end
                end
                default: begin
                    r_por_cnt <= r_por_cnt;
                    r_stg_cnt <= r_stg_cnt;
                    r_slot    <= r_slot;
                end
            endcase
        end
    end

    // Core k may leave reset once its slot has ended; disabled cores still
    // burn their slot so the release timing never depends on the mask.
    always_comb begin
        w_go = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (r_state == ST_RUN) begin
                w_go[k] = 1'b1;
            end else if (r_state == ST_REL) begin
                w_go[k] = (r_slot > SLOT_W'(k)) ||
                          ((r_slot == SLOT_W'(k)) && w_slot_end);
            end else begin
                w_go[k] = 1'b0;
            end
        end
    end

    for (genvar k = 0; k < NUM_CORES; k++) begin : g_core
        orpsoc_core_wdt #(
            .HOLD_CYCLES (HOLD_CYCLES),
            .WDT_CYCLES  (WDT_CYCLES)
        ) u_core (
            .wb_clk_i   (wb_clk_i),
            .wb_rst_ni  (wb_rst_ni),
            .i_run      (w_run),
            .i_go       (w_go[k]),
            .i_en       (bus.core_en_i[k]),
            .i_soft_req (bus.soft_rst_req_i[k]),
            .i_alive    (bus.core_alive_i[k]),
            .i_wdt_clr  (bus.wdt_clr_i),
            .o_core_rst (w_core_rst[k]),
            .o_timeout  (w_timeout[k])
        );
    end

    assign bus.sys_rst_o      = r_sys_rst;
    assign bus.seq_done_o     = r_seq_done;
    assign bus.core_rst_o     = w_core_rst;
    assign bus.core_timeout_o = w_timeout;

endmodule
